uart_link: RTL

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_link.sv
// 8N1 UART link with a command FSM (send / receive byte) and a continuously running receiver.
// Define UART_LINK_RXFIFO_EN for a 4-entry receive FIFO; otherwise the buffer is a single holding register.
module uart_link #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_go,
  input  logic       rors,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       uart_done,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_overrun
);

  // state   | meaning
  // IDLE    | waiting for uart_go
  // TX_BUSY | shifting a frame out on txd
  // RX_WAIT | waiting for a byte in the receive buffer
  // DONE    | one-cycle completion pulse

  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_LINK_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MEM_N = 1 << PW;

  typedef enum logic [1:0] {IDLE, TX_BUSY, RX_WAIT, DONE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t      r_state, w_state_nxt;
  rx_state_t   r_rx_state, w_rx_state_nxt;

  logic [9:0]  r_tx_shift;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_nbit;
  logic        r_txd;

  logic        r_rxd_s1, r_rxd_s2, r_rxd_prev;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;

  logic [7:0]  r_mem [MEM_N];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_fifo_cnt;
  logic [7:0]  r_rx_data;
  logic        r_overrun;

  logic w_tx_tick, w_go_tx, w_pop, w_full, w_wr;
  logic w_rx_fall, w_rx_tick, w_rx_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_tx_tick = (r_state == TX_BUSY) && (r_tx_cnt == 16'd0);
  assign w_go_tx   = (r_state == IDLE) && uart_go && rors;
  assign w_full    = (r_fifo_cnt == CW'(DEPTH));
  assign w_pop     = (r_state == RX_WAIT) && (r_fifo_cnt != '0);
  assign w_wr      = w_rx_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (uart_go) w_state_nxt = rors ? TX_BUSY : RX_WAIT;
      TX_BUSY: if (w_tx_tick && (r_tx_nbit == 4'd0)) w_state_nxt = DONE;
      RX_WAIT: if (w_pop) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter starts at 0 so the start bit appears on the first edge in TX_BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_nbit  <= '0;
      r_txd      <= 1'b1;
    end else if (w_go_tx) begin
      r_tx_shift <= {1'b1, tx_data, 1'b0};
      r_tx_cnt   <= '0;
      r_tx_nbit  <= 4'd10;
    end else if (r_state == TX_BUSY) begin
      if (r_tx_cnt != 16'd0) begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end else if (r_tx_nbit != 4'd0) begin
        r_txd      <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_cnt   <= BIT_M1;
        r_tx_nbit  <= r_tx_nbit - 4'd1;
      end
    end
  end

  assign w_rx_fall = r_rxd_prev && !r_rxd_s2;
  assign w_rx_tick = (r_rx_cnt == 16'd0);
  assign w_rx_push = (r_rx_state == RX_STOP) && w_rx_tick && r_rxd_s2;

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_tick) w_rx_state_nxt = r_rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_state_nxt = RX_IDLE;
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Synchronizers reset high so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_prev <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rxd_s1   <= rxd;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_prev <= r_rxd_s2;
      r_rx_state <= w_rx_state_nxt;
      case (r_rx_state)
        RX_IDLE: if (w_rx_fall) r_rx_cnt <= HALF_M1;
        RX_START: begin
          if (w_rx_tick) begin
            r_rx_cnt <= BIT_M1;
            r_rx_bit <= '0;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            r_rx_cnt   <= BIT_M1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RX_STOP: if (!w_rx_tick) r_rx_cnt <= r_rx_cnt - 16'd1;
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  // A pop reads the head before a same-edge write can replace it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_rx_data  <= 8'h00;
      r_overrun  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr  <= ptr_inc(r_rd_ptr);
        r_rx_data <= r_mem[r_rd_ptr];
      end
      if (w_wr && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_wr && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
      if (w_rx_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  assign txd        = r_txd;
  assign uart_done  = (r_state == DONE);
  assign rx_data    = r_rx_data;
  assign rx_overrun = r_overrun;

endmodule
